// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD decode path: digit limits,
// correction constants and the converter's state encoding.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W     = 4;
    localparam logic [3:0]  BCD_MAX_DIGIT   = 4'd9;
    localparam logic [3:0]  BCD_CORR_THRESH = 4'd8;
    localparam logic [3:0]  BCD_CORR_VAL    = 4'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } bcd_state_t;

    function automatic logic bcd_digit_ok(input logic [3:0] digit);
        return (digit <= BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Start/done handshake bundle between entry logic (master) and the
// BCD-to-binary converter (slave).
interface bcd_to_binary_seq_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  ready;
    logic                  done;
    logic [BIN_W-1:0]      binary;
    logic                  invalid;
    logic                  overflow;

    modport master (
        output start, bcd_in,
        input  ready, done, binary, invalid, overflow
    );

    modport slave (
        input  start, bcd_in,
        output ready, done, binary, invalid, overflow
    );
endinterface

// File: rtl/bcd_digit_correct.sv
// Reverse double-dabble digit fix-up: a shifted digit of 8 or more
// has 3 removed so it stays a legal BCD digit.
module bcd_digit_correct
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Conditional subtract-3 correction for one digit
    always_comb begin
        dout = din;
        if (din >= BCD_CORR_THRESH) begin
            dout = din - BCD_CORR_VAL;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter: one right shift plus per-digit
// correction per clock, with a start/done handshake.
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_to_binary_seq_if.slave bus
);

    localparam int ACC_W  = BCD_DIGIT_W * DIGITS;
    localparam int WORK_W = 2 * ACC_W;
    localparam int CNT_W  = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(ACC_W - 1);

    bcd_state_t              state_r, state_s;
    logic [WORK_W-1:0]       work_r, work_s, shifted_s;
    logic [ACC_W-1:0]        corr_s;
    logic [BIN_W+ACC_W-1:0]  acc_ext_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic [BIN_W-1:0]        binary_r, binary_s;
    logic                    ready_r, ready_s;
    logic                    done_r, done_s;
    logic                    invalid_r, invalid_s;
    logic                    overflow_r, overflow_s;
    logic                    bad_r, bad_s;
    logic                    accept_s;

    function automatic logic all_digits_ok(input logic [ACC_W-1:0] bcd);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            ok = ok & bcd_digit_ok(bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
        return ok;
    endfunction

    assign shifted_s = work_r >> 1;
    assign acc_ext_s = {{BIN_W{1'b0}}, work_r[ACC_W-1:0]};
    assign accept_s  = (state_r == IDLE) && ready_r && bus.start;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_corr
            bcd_digit_correct u_corr (
                .din  (shifted_s[ACC_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .dout (corr_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Next-state, datapath and output computation
    always_comb begin
        state_s    = state_r;
        work_s     = work_r;
        cnt_s      = cnt_r;
        ready_s    = ready_r;
        done_s     = 1'b0;
        binary_s   = binary_r;
        invalid_s  = invalid_r;
        overflow_s = overflow_r;
        bad_s      = bad_r;
        case (state_r)
            IDLE: begin
                ready_s = 1'b1;
                if (accept_s) begin
                    ready_s    = 1'b0;
                    invalid_s  = 1'b0;
                    overflow_s = 1'b0;
                    cnt_s      = {CNT_W{1'b0}};
                    if (all_digits_ok(bus.bcd_in)) begin
                        bad_s   = 1'b0;
                        work_s  = {bus.bcd_in, {ACC_W{1'b0}}};
                        state_s = SHIFT;
                    end else begin
                        bad_s   = 1'b1;
                        state_s = FINISH;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                work_s = {corr_s, shifted_s[ACC_W-1:0]};
                cnt_s  = cnt_r + CNT_W'(1);
                if (cnt_r == LAST_SHIFT) begin
                    state_s = FINISH;
                end else begin
                    state_s = SHIFT;
                end
            end
            FINISH: begin
                // ready stays low through the done cycle so a start there is dropped
                done_s  = 1'b1;
                ready_s = 1'b0;
                state_s = IDLE;
                if (bad_r) begin
                    binary_s   = {BIN_W{1'b0}};
                    invalid_s  = 1'b1;
                    overflow_s = 1'b0;
                end else begin
                    binary_s   = acc_ext_s[BIN_W-1:0];
                    invalid_s  = 1'b0;
                    overflow_s = |(acc_ext_s >> BIN_W);
                end
            end
            default: begin
                state_s = IDLE;
                ready_s = 1'b1;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            work_r     <= {WORK_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            binary_r   <= {BIN_W{1'b0}};
            invalid_r  <= 1'b0;
            overflow_r <= 1'b0;
            bad_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            work_r     <= work_s;
            cnt_r      <= cnt_s;
            ready_r    <= ready_s;
            done_r     <= done_s;
            binary_r   <= binary_s;
            invalid_r  <= invalid_s;
            overflow_r <= overflow_s;
            bad_r      <= bad_s;
        end
    end

    assign bus.ready    = ready_r;
    assign bus.done     = done_r;
    assign bus.binary   = binary_r;
    assign bus.invalid  = invalid_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Scoreboarded random/directed bench for bcd_to_binary_seq at BIN_W=10
// and BIN_W=8, against an arithmetic decimal reference model.
module tb_bcd_to_binary_seq;

    typedef struct {
        int bin;
        int inv;
        int ovf;
        int cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   pass_cnt;
    int   chk_cnt;
    exp_t q10[$];
    exp_t q8[$];
    bit   rdy_next10;

    bcd_to_binary_seq_if #(.DIGITS(3), .BIN_W(10)) if10 ();
    bcd_to_binary_seq_if #(.DIGITS(3), .BIN_W(8))  if8 ();

    bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) u_dut10 (.clk(clk), .rst_n(rst_n), .bus(if10));
    bcd_to_binary_seq #(.DIGITS(3), .BIN_W(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Decimal reference: value = 100*h + 10*t + o, reduced modulo 2**w
    function automatic exp_t model(input logic [11:0] bcd, input int w);
        exp_t e;
        int   h, t, o, n;
        h = int'(bcd[11:8]);
        t = int'(bcd[7:4]);
        o = int'(bcd[3:0]);
        e.cyc = 0;
        if (h > 9 || t > 9 || o > 9) begin
            e.bin = 0; e.inv = 1; e.ovf = 0;
        end else begin
            n = h * 100 + t * 10 + o;
            e.bin = n % (1 << w);
            e.inv = 0;
            e.ovf = (n >= (1 << w)) ? 1 : 0;
        end
        return e;
    endfunction

    task automatic issue(input int sel, input logic [11:0] bcd);
        exp_t e;
        int   i;
        i = 0;
        @(negedge clk);
        while (((sel == 0) ? if10.ready : if8.ready) !== 1'b1 && i < 40) begin
            @(negedge clk);
            i++;
        end
        if (i >= 40) chk("ready_timeout", 0, 1);
        e = model(bcd, (sel == 0) ? 10 : 8);
        if (sel == 0) begin if10.start = 1'b1; if10.bcd_in = bcd; end
        else          begin if8.start  = 1'b1; if8.bcd_in  = bcd; end
        @(posedge clk);
        #1;
        e.cyc = cyc + ((e.inv == 1) ? 1 : 13);
        if (sel == 0) q10.push_back(e); else q8.push_back(e);
        if10.start = 1'b0;
        if8.start  = 1'b0;
        // bcd_in changes after capture must not matter
        if (sel == 0) if10.bcd_in = 12'($urandom); else if8.bcd_in = 12'($urandom);
    endtask

    task automatic wait_idle(input int sel);
        int i;
        i = 0;
        while (((sel == 0) ? q10.size() : q8.size()) != 0 && i < 40) begin
            @(negedge clk);
            i++;
        end
        if (i >= 40) begin
            chk("done_timeout", 0, 1);
            if (sel == 0) q10.delete(); else q8.delete();
        end
    endtask

    task automatic convert(input int sel, input logic [11:0] bcd);
        issue(sel, bcd);
        wait_idle(sel);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready10"}, int'(if10.ready), 1);
        chk({tag, "_done10"}, int'(if10.done), 0);
        chk({tag, "_binary10"}, int'(if10.binary), 0);
        chk({tag, "_invalid10"}, int'(if10.invalid), 0);
        chk({tag, "_overflow10"}, int'(if10.overflow), 0);
        chk({tag, "_binary8"}, int'(if8.binary), 0);
        chk({tag, "_ready8"}, int'(if8.ready), 1);
    endtask

    // Monitor: pop and compare whenever a converter presents done
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rdy_next10) begin
            chk("ready_after_done10", int'(if10.ready), 1);
        end
        rdy_next10 = 1'b0;
        if (rst_n && if10.done === 1'b1) begin
            if (q10.size() == 0) chk("unexpected_done10", 1, 0);
            else begin
                e = q10.pop_front();
                chk("binary10", int'(if10.binary), e.bin);
                chk("invalid10", int'(if10.invalid), e.inv);
                chk("overflow10", int'(if10.overflow), e.ovf);
                chk("latency10", cyc, e.cyc);
                chk("ready_in_done10", int'(if10.ready), 0);
                rdy_next10 = 1'b1;
            end
        end
        if (rst_n && if8.done === 1'b1) begin
            if (q8.size() == 0) chk("unexpected_done8", 1, 0);
            else begin
                e = q8.pop_front();
                chk("binary8", int'(if8.binary), e.bin);
                chk("invalid8", int'(if8.invalid), e.inv);
                chk("overflow8", int'(if8.overflow), e.ovf);
                chk("latency8", cyc, e.cyc);
            end
        end
    end

    initial begin
        logic [11:0] v;
        int          i;
        cyc = 0; pass_cnt = 0; chk_cnt = 0; rdy_next10 = 1'b0;
        rst_n = 1'b0;
        if10.start = 1'b0; if10.bcd_in = 12'h000;
        if8.start  = 1'b0; if8.bcd_in  = 12'h000;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        convert(0, 12'h999);
        convert(0, 12'h000);
        convert(1, 12'h255);
        convert(1, 12'h256);
        convert(0, 12'h1A3);

        // Random entries, roughly one digit in six illegal
        for (int k = 0; k < 30; k++) begin
            v = 12'h000;
            for (int d = 0; d < 3; d++) begin
                if ($urandom_range(0, 5) == 0) v[d*4 +: 4] = 4'($urandom_range(10, 15));
                else                           v[d*4 +: 4] = 4'($urandom_range(0, 9));
            end
            convert(k % 2, v);
        end

        // Start while busy and start during the done cycle are both dropped
        issue(0, 12'h123);
        repeat (4) @(negedge clk);
        if10.start = 1'b1; if10.bcd_in = 12'h456;
        @(negedge clk);
        if10.start = 1'b0;
        i = 0;
        while (if10.done !== 1'b1 && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("done_seen_123", int'(if10.done), 1);
        if10.start = 1'b1; if10.bcd_in = 12'h456;
        @(posedge clk);
        #1;
        if10.start = 1'b0;
        repeat (20) @(negedge clk);
        chk("hold_binary_123", int'(if10.binary), 123);
        chk("idle_ready_123", int'(if10.ready), 1);

        // Asynchronous reset in the middle of a conversion
        issue(0, 12'h789);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        q10.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_done_after_reset", int'(if10.binary), 0);
        convert(0, 12'h042);

        // Round trip through a decimal split of every 8-bit value
        for (int n = 0; n < 256; n++) begin
            v = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
            convert(1, v);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
